seven_segment_animation_sequencer: RTL and testbench
====================================================

// Module: seven_segment_animation_sequencer
// PURPOSE
//   Producer side of the frame/frame_valid interface consumed by seven_segment_animation.
//   - Steps a 3b frame index through the 8-step figure-8 at a programmable rate.
//   - Supports start/stop/pause, forward or reverse direction, and N laps or endless looping.
//   - Sits between the control/CSR logic and the seven-segment decode path.
// PARAMETERS
//   TICK_W          24          width of frame-period counter and period input
//   DEFAULT_PERIOD  12_500_000  period used when period input is 0 at start
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   start        in   1       1-cycle request to begin an animation; ignored while busy
//   stop         in   1       1-cycle abort request
//   pause        in   1       level; high freezes the animation
//   reverse      in   1       direction, latched at start: 0 = 0->7, 1 = 7->0
//   period       in   TICK_W  clk cycles per frame, latched at start; 0 -> DEFAULT_PERIOD
//   laps         in   8       full laps to play, latched at start; 0 = loop until stop
//   frame        out  3       current frame index
//   frame_valid  out  1       high while animating (RUN or HOLD)
//   busy         out  1       state != IDLE
//   lap_done     out  1       1-cycle pulse on every lap wrap
//   done         out  1       1-cycle pulse when the final lap completes; never on stop
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, tick count 0, lap counter 0.
//   All outputs are registered.
//   FSM states: IDLE, RUN, HOLD.
//   IDLE:
//     - frame = 0, frame_valid = 0.
//     - start & !stop -> RUN. Latch reverse, period, laps.
//     - Load frame = reverse ? 7 : 0 and tick = 0.
//     - Latency: start sampled at edge N gives frame_valid = 1 from cycle N+1.
//   RUN:
//     - tick increments every cycle.
//     - When tick == period_q-1: tick <= 0, frame <= frame +/- 1 (mod 8).
//     - Each frame is therefore shown for exactly period_q cycles.
//   Wrap (advance 7->0 forward, or 0->7 reverse):
//     - lap_done pulses in the same cycle the new frame appears.
//     - If laps_q != 0 and this was the last lap: go to IDLE instead.
//     - In that case frame = 0, frame_valid = 0, done = 1 and lap_done = 1 in the same cycle.
//   laps_q = 0: wraps forever. The lap counter does not count.
//   pause high in RUN -> HOLD:
//     - tick and frame are frozen; frame_valid stays 1.
//     - pause low -> RUN; counting resumes from the frozen tick value.
//   stop in RUN or HOLD -> IDLE next cycle: frame = 0, frame_valid = 0, no done, no lap_done.
//   Priority: rst > stop > pause > tick advance.
//   stop + start in the same IDLE cycle: stay in IDLE.
//   start while busy: ignored; latched config is unchanged.
//   Live changes to period/reverse/laps while busy have no effect.
//   period_q = 1: frame advances every cycle.
//   laps = 255: exactly 255 laps, then done.
//   rst mid-animation: next cycle matches the reset values.
// STRUCTURE
//   Package seven_segment_pkg:
//     - FRAME_W = 3, FRAME_FIRST = 3'h0, FRAME_LAST = 3'h7.
//     - typedef enum logic [1:0] anim_state_t {IDLE, RUN, HOLD}.
//     - typedef logic [FRAME_W-1:0] frame_t.
//   Sub-module frame_tick_prescaler (TICK_W):
//     - Inputs: clk, rst, clear, enable, period.
//     - Output: tick, a 1-cycle pulse when count == period-1; count then reloads 0.
//   Top contains the FSM, the frame counter, the lap counter and the output registers.
// TESTING
//   1. period=4, laps=1, reverse=0, start at cycle 0:
//      - frame_valid = 1 in cycles 1-32; frame = 0,1,...,7, each held 4 cycles.
//      - Cycle 33: frame_valid = 0, done = 1, lap_done = 1.
//   2. period=2, laps=2, reverse=1:
//      - frame = 7..0 twice.
//      - lap_done at the mid wrap (frame -> 7, frame_valid stays 1); done only at the end.
//   3. laps=0, period=1:
//      - Runs 40 cycles; lap_done every 8 cycles; no done.
//      - stop -> IDLE next cycle with frame = 0 and no done.
//   4. pause 10 cycles mid-frame (tick=2 of period 4):
//      - frame held; frame_valid = 1.
//      - After release the frame advances 2 cycles later.
//   5. Corner cases:
//      - start while busy with new period/reverse: ignored, sequence unchanged.
//      - start + stop in the same cycle from IDLE: stays IDLE.
//      - stop + pause + tick in the same cycle: IDLE.
//   6. rst asserted mid-RUN; period=0 at start:
//      - rst: all outputs 0 next cycle.
//      - period=0: first advance after DEFAULT_PERIOD, checked with a reduced parameter (e.g. 5).

Source files
------------

// File: rtl/seven_segment_animation_sequencer_pkg.sv
// Shared types and constants for the seven-segment figure-8 animation path.
package seven_segment_pkg;

  localparam int FRAME_W = 3;
  localparam logic [FRAME_W-1:0] FRAME_FIRST = 3'h0;
  localparam logic [FRAME_W-1:0] FRAME_LAST  = 3'h7;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} anim_state_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Next frame index in the selected direction; mod-8 wrap comes from the width.
  function automatic frame_t frame_step(input frame_t f, input logic rev);
    return rev ? frame_t'(f - 1'b1) : frame_t'(f + 1'b1);
  endfunction

endpackage

// File: rtl/seven_segment_animation_sequencer_tick.sv
// Frame-period prescaler: one-cycle tick every `period` enabled cycles.
module frame_tick_prescaler #(
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] count_q;

  assign tick = enable && (count_q == period - TICK_W'(1));

  // Disabled cycles hold the count, which is what makes pause resume mid-frame.
  always_ff @(posedge clk) begin
    if (rst || clear)  count_q <= '0;
    else if (enable)   count_q <= tick ? '0 : count_q + TICK_W'(1);
  end

endmodule

// File: rtl/seven_segment_animation_sequencer.sv
// Figure-8 frame sequencer: start/stop/pause, direction, N laps or endless.
module seven_segment_animation_sequencer
  import seven_segment_pkg::*;
#(
  parameter int          TICK_W         = 24,
  parameter int unsigned DEFAULT_PERIOD = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              reverse,
  input  logic [TICK_W-1:0] period,
  input  logic [7:0]        laps,
  output logic [2:0]        frame,
  output logic              frame_valid,
  output logic              busy,
  output logic              lap_done,
  output logic              done
);

  anim_state_t       state_q, state_d;
  frame_t            frame_q, frame_d;
  logic [7:0]        lap_cnt_q, lap_cnt_d;
  logic [7:0]        laps_q;
  logic [TICK_W-1:0] period_q;
  logic              reverse_q;
  logic              load_cfg, lap_done_d, done_d;
  logic              tick, wrap;
  logic              valid_q, busy_q, lap_done_q, done_q;

  frame_tick_prescaler #(.TICK_W(TICK_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .enable ((state_q != IDLE) && !stop && !pause),
    .period (period_q),
    .tick   (tick)
  );

  assign wrap = reverse_q ? (frame_q == FRAME_FIRST) : (frame_q == FRAME_LAST);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    lap_cnt_d  = lap_cnt_q;
    lap_done_d = 1'b0;
    done_d     = 1'b0;
    load_cfg   = 1'b0;
    unique case (state_q)
      IDLE: begin
        frame_d   = FRAME_FIRST;
        lap_cnt_d = '0;
        if (start && !stop) begin
          state_d  = RUN;
          load_cfg = 1'b1;
          frame_d  = reverse ? FRAME_LAST : FRAME_FIRST;
        end
      end
      RUN, HOLD: begin
        if (stop) begin
          state_d = IDLE;
          frame_d = FRAME_FIRST;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          // Leaving HOLD counts in the same cycle so a pause freezes exactly its own length.
          state_d = RUN;
          if (tick) begin
            frame_d = frame_step(frame_q, reverse_q);
            if (wrap) begin
              lap_done_d = 1'b1;
              if (laps_q != 8'd0) begin
                if (lap_cnt_q == laps_q - 8'd1) begin
                  state_d = IDLE;
                  frame_d = FRAME_FIRST;
                  done_d  = 1'b1;
                end else begin
                  lap_cnt_d = lap_cnt_q + 8'd1;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= FRAME_FIRST;
      lap_cnt_q  <= '0;
      laps_q     <= '0;
      period_q   <= '0;
      reverse_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      lap_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      lap_cnt_q  <= lap_cnt_d;
      valid_q    <= (state_d != IDLE);
      busy_q     <= (state_d != IDLE);
      lap_done_q <= lap_done_d;
      done_q     <= done_d;
      if (load_cfg) begin
        reverse_q <= reverse;
        laps_q    <= laps;
        period_q  <= (period == '0) ? TICK_W'(DEFAULT_PERIOD) : period;
      end
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;
  assign lap_done    = lap_done_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seven_segment_animation_sequencer.sv
// Scoreboard bench: stimulus queues expected output cycles, monitor pops on any DUT output.
module tb_seven_segment_animation_sequencer;

  typedef struct packed {
    logic [2:0] frame;
    logic       valid;
    logic       busy;
    logic       lap_done;
    logic       done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, reverse;
  logic [23:0] period;
  logic [7:0]  laps;
  logic [2:0]  frame;
  logic        frame_valid, busy, lap_done, done;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  seven_segment_animation_sequencer #(.TICK_W(24), .DEFAULT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .reverse(reverse), .period(period), .laps(laps),
    .frame(frame), .frame_valid(frame_valid), .busy(busy),
    .lap_done(lap_done), .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: any cycle showing valid/lap_done/done must match the next queued entry.
  initial begin
    obs_t act, e;
    forever begin
      @(negedge clk);
      if (frame_valid || lap_done || done) begin
        act = '{frame, frame_valid, busy, lap_done, done};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got frame=%0d valid=%0b busy=%0b lap_done=%0b done=%0b, none expected",
                   act.frame, act.valid, act.busy, act.lap_done, act.done);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL trace t=%0t: got frame=%0d valid=%0b busy=%0b lap_done=%0b done=%0b, expected frame=%0d valid=%0b busy=%0b lap_done=%0b done=%0b",
                     $time, act.frame, act.valid, act.busy, act.lap_done, act.done,
                     e.frame, e.valid, e.busy, e.lap_done, e.done);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int fr, input logic v, input logic ld, input logic dn);
    exp_q.push_back('{3'(fr), v, v, ld, dn});
  endtask

  // Full animation: each frame held `per` cycles, optional extra cycles on the first frame.
  task automatic exp_seq(input logic rev, input int per, input int nlaps, input int extra0);
    for (int l = 0; l < nlaps; l++)
      for (int s = 0; s < 8; s++)
        for (int c = 0; c < per + ((l == 0 && s == 0) ? extra0 : 0); c++)
          push(rev ? 7 - s : s, 1'b1, (l > 0 && s == 0 && c == 0), 1'b0);
    push(0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_start(input logic rv, input int per, input int lp);
    reverse = rv; period = 24'(per); laps = 8'(lp); start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d expected outputs never appeared, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    cyc(3);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_frame"}, frame, 0);
    chk({nm, "_valid"}, frame_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_lap_done"}, lap_done, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    reverse = 1'b0; period = '0; laps = '0;
    cyc(3);
    chk_idle("reset");
    rst = 1'b0;
    cyc(2);

    // 1: forward, period 4, one lap
    exp_seq(1'b0, 4, 1, 0);
    do_start(1'b0, 4, 1);
    drain("fwd_p4", 60);

    // 2: reverse, period 2, two laps
    exp_seq(1'b1, 2, 2, 0);
    do_start(1'b1, 2, 2);
    drain("rev_p2_l2", 60);

    // 3: endless at period 1, stop after 40 cycles
    for (int i = 0; i < 40; i++) push(i % 8, 1'b1, (i > 0 && i % 8 == 0), 1'b0);
    do_start(1'b0, 1, 0);
    cyc(39);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_idle("stop_endless");
    drain("endless", 10);

    // 4: pause 10 cycles while tick count is 2 of period 4
    exp_seq(1'b0, 4, 1, 10);
    do_start(1'b0, 4, 1);
    cyc(2);
    pause = 1'b1;
    cyc(10);
    pause = 1'b0;
    drain("pause", 80);

    // 5a: start while busy with different config is ignored
    exp_seq(1'b0, 2, 1, 0);
    do_start(1'b0, 2, 1);
    cyc(4);
    reverse = 1'b1; period = 24'd7; laps = 8'd5; start = 1'b1;
    cyc(1);
    start = 1'b0;
    drain("start_busy", 40);

    // 5b: start and stop together from IDLE
    reverse = 1'b0; period = 24'd2; laps = 8'd1;
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk_idle("start_stop");
    cyc(3);

    // 5c: stop, pause and a tick in the same cycle
    push(0, 1'b1, 1'b0, 1'b0); push(1, 1'b1, 1'b0, 1'b0); push(2, 1'b1, 1'b0, 1'b0);
    do_start(1'b0, 1, 0);
    cyc(2);
    stop = 1'b1; pause = 1'b1;
    cyc(1);
    stop = 1'b0; pause = 1'b0;
    chk_idle("stop_pause_tick");
    drain("stop_pause_tick", 5);

    // 6a: reset mid-run
    for (int i = 0; i < 6; i++) push(i / 4, 1'b1, 1'b0, 1'b0);
    do_start(1'b0, 4, 0);
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_idle("rst_mid");
    drain("rst_mid", 5);

    // 6b: period 0 falls back to the default (5 in this build)
    exp_seq(1'b0, 5, 1, 0);
    do_start(1'b0, 0, 1);
    drain("default_period", 60);

    // laps = 255 runs exactly 255 laps at period 1
    exp_seq(1'b0, 1, 255, 0);
    do_start(1'b0, 1, 255);
    drain("laps255", 2100);
    chk_idle("after_laps255");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
